// File: rtl/alu_seq_if.sv
// Handshake bus between the operand issue logic, alu_seq and the result writeback.
// The issue side uses the master modport and alu_seq uses the slave modport.
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SEL_W-1:0] sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, s, overflow, illegal
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, s, overflow, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and an iterative shift-add multiplier.
// Define ALU_SEQ_SHIFT_AMT_EN to make SHL/SHR shift by b[$clog2(WIDTH)-1:0] instead of by 1.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 5
) (
  input logic     clk,
  input logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [SEL_W-1:0] OP_ADD = SEL_W'(1);
  localparam logic [SEL_W-1:0] OP_AND = SEL_W'(2);
  localparam logic [SEL_W-1:0] OP_EQ  = SEL_W'(3);
  localparam logic [SEL_W-1:0] OP_GT  = SEL_W'(4);
  localparam logic [SEL_W-1:0] OP_SHL = SEL_W'(5);
  localparam logic [SEL_W-1:0] OP_SHR = SEL_W'(6);
  localparam logic [SEL_W-1:0] OP_MUL = SEL_W'(7);
  localparam logic [SEL_W-1:0] OP_SUB = SEL_W'(8);
  localparam logic [SEL_W-1:0] OP_OR  = SEL_W'(9);
  localparam logic [SEL_W-1:0] OP_XOR = SEL_W'(10);

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               ovf_q, ovf_d;
  logic               ill_q, ill_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               alu_ill;
  logic [WIDTH:0]     sum_w;

`ifdef ALU_SEQ_SHIFT_AMT_EN
  localparam int SH_W = $clog2(WIDTH);
  logic [SH_W-1:0] shamt;
  assign shamt = bus.b[SH_W-1:0];
`endif

  // Single-cycle opcodes, evaluated on the live bus so the result is captured on the accept edge.
  always_comb begin
    alu_res = {WIDTH{1'b0}};
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    sum_w   = {1'b0, bus.a} + {1'b0, bus.b};
    case (bus.sel)
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_ovf = sum_w[WIDTH];
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_EQ:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
      OP_GT:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a > bus.b)};
`ifdef ALU_SEQ_SHIFT_AMT_EN
      OP_SHL: begin
        alu_res = bus.a << shamt;
        alu_ovf = |(bus.a & ~({WIDTH{1'b1}} >> shamt));
      end
      OP_SHR: begin
        alu_res = bus.a >> shamt;
        alu_ovf = |(bus.a & ~({WIDTH{1'b1}} << shamt));
      end
`else
      OP_SHL: begin
        alu_res = {bus.a[WIDTH-2:0], 1'b0};
        alu_ovf = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, bus.a[WIDTH-1:1]};
        alu_ovf = bus.a[0];
      end
`endif
      OP_SUB: begin
        alu_res = bus.a - bus.b;
        alu_ovf = (bus.a < bus.b);
      end
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_MUL: alu_res = {WIDTH{1'b0}};
      default: alu_ill = 1'b1;
    endcase
  end

  // The last multiplier bit is folded in on the same edge that enters DONE, giving WIDTH+1 latency.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.sel == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = {{WIDTH{1'b0}}, bus.a};
            mplier_d = bus.b;
            acc_d    = {(2*WIDTH){1'b0}};
            cnt_d    = {CNT_W{1'b0}};
          end else begin
            state_d = S_DONE;
            s_d     = alu_res;
            ovf_d   = alu_ovf;
            ill_d   = alu_ill;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_W'(WIDTH)) begin
          state_d = S_DONE;
          s_d     = acc_d[WIDTH-1:0];
          ovf_d   = |acc_d[2*WIDTH-1:WIDTH];
          ill_d   = 1'b0;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mcand_q     <= {(2*WIDTH){1'b0}};
      mplier_q    <= {WIDTH{1'b0}};
      acc_q       <= {(2*WIDTH){1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      s_q         <= {WIDTH{1'b0}};
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed vector table, randomized ops
// against an arithmetic reference model, back-pressure and mid-multiply reset sequences.
module tb_alu_seq;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.WIDTH(W), .SEL_W(5)) bus ();

  alu_seq #(.WIDTH(W), .SEL_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sel;
    logic [31:0] s;
    logic        ovf;
    logic        ill;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model written directly from the opcode table using wide arithmetic.
  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sel,
                                 output logic [31:0] s, output logic ovf, output logic ill);
    logic [63:0] w;
    s = 32'd0; ovf = 1'b0; ill = 1'b0;
    case (sel)
      5'd1: begin w = 64'(a) + 64'(b); s = w[31:0]; ovf = w[32]; end
      5'd2: s = a & b;
      5'd3: s = (a == b) ? 32'd1 : 32'd0;
      5'd4: s = (a > b) ? 32'd1 : 32'd0;
`ifdef ALU_SEQ_SHIFT_AMT_EN
      5'd5: begin w = {32'd0, a} << b[4:0]; s = w[31:0];  ovf = |w[63:32]; end
      5'd6: begin w = {a, 32'd0} >> b[4:0]; s = w[63:32]; ovf = |w[31:0];  end
`else
      5'd5: begin s = a << 1; ovf = a[31]; end
      5'd6: begin s = a >> 1; ovf = a[0];  end
`endif
      5'd7: begin w = 64'(a) * 64'(b); s = w[31:0]; ovf = |w[63:32]; end
      5'd8: begin s = a - b; ovf = (a < b); end
      5'd9: s = a | b;
      5'd10: s = a ^ b;
      default: ill = 1'b1;
    endcase
  endfunction

  // Issue one op with out_ready=1, return the result and its latency in cycles.
  task automatic run_op(input logic [31:0] a_i, input logic [31:0] b_i, input logic [4:0] sel_i,
                        output logic [31:0] s_o, output logic ovf_o, output logic ill_o,
                        output int lat_o);
    int   guard;
    logic busy_bad;
    guard = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a = a_i; bus.b = b_i; bus.sel = sel_i;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.sel = 5'($urandom);
    lat_o = 1;
    busy_bad = 1'b0;
    while (!bus.out_valid && lat_o < 200) begin
      if (bus.in_ready) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat_o++;
    end
    if (bus.in_ready) busy_bad = 1'b1;
    chk("in_ready_busy", 64'(busy_bad), 64'd0);
    s_o = bus.s; ovf_o = bus.overflow; ill_o = bus.illegal;
    @(posedge clk); #1;
    chk("in_ready_after_consume", 64'(bus.in_ready), 64'd1);
  endtask

  vec_t        vecs[$];
  logic [31:0] rs, es;
  logic        rovf, rill, eovf, eill;
  int          rlat;
  logic        held_bad;

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = 32'd0; bus.b = 32'd0; bus.sel = 5'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_s", 64'(bus.s), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    //        a             b             sel    s             ovf   ill   lat
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 5'd1,  32'h00000000, 1'b1, 1'b0, 1});
    vecs.push_back('{32'h00010000, 32'h00010000, 5'd7,  32'h00000000, 1'b1, 1'b0, 33});
    vecs.push_back('{32'h00000007, 32'h00000006, 5'd7,  32'h0000002A, 1'b0, 1'b0, 33});
    vecs.push_back('{32'h00000003, 32'h00000005, 5'd8,  32'hFFFFFFFE, 1'b1, 1'b0, 1});
    vecs.push_back('{32'h00001234, 32'h00001234, 5'd3,  32'h00000001, 1'b0, 1'b0, 1});
    vecs.push_back('{32'h00000005, 32'h00000009, 5'd4,  32'h00000000, 1'b0, 1'b0, 1});
    vecs.push_back('{32'h00000009, 32'h00000005, 5'd4,  32'h00000001, 1'b0, 1'b0, 1});
    vecs.push_back('{32'h00000005, 32'h00000006, 5'd0,  32'h00000000, 1'b0, 1'b1, 1});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'h00000000, 1'b0, 1'b1, 1});
    vecs.push_back('{32'h00000001, 32'h00000001, 5'd1,  32'h00000002, 1'b0, 1'b0, 1});
    vecs.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 5'd2,  32'hF000F000, 1'b0, 1'b0, 1});
    vecs.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 5'd9,  32'hFFF0FFF0, 1'b0, 1'b0, 1});
    vecs.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 5'd10, 32'h0FF00FF0, 1'b0, 1'b0, 1});
    vecs.push_back('{32'h80000001, 32'h00000001, 5'd5,  32'h00000002, 1'b1, 1'b0, 1});
    vecs.push_back('{32'h00000003, 32'h00000001, 5'd6,  32'h00000001, 1'b1, 1'b0, 1});
    vecs.push_back('{32'h00000004, 32'h00000007, 5'd11, 32'h00000000, 1'b0, 1'b1, 1});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000001, 1'b1, 1'b0, 33});

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sel, rs, rovf, rill, rlat);
      chk($sformatf("vec%0d_s", i), 64'(rs), 64'(vecs[i].s));
      chk($sformatf("vec%0d_ovf", i), 64'(rovf), 64'(vecs[i].ovf));
      chk($sformatf("vec%0d_ill", i), 64'(rill), 64'(vecs[i].ill));
      chk($sformatf("vec%0d_lat", i), 64'(rlat), 64'(vecs[i].lat));
    end

    // Randomized ops against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] ra, rb;
      logic [4:0]  rsel;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 40));
      rsel = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 11));
      ref_op(ra, rb, rsel, es, eovf, eill);
      run_op(ra, rb, rsel, rs, rovf, rill, rlat);
      chk($sformatf("rnd%0d_sel%0d_s", n, rsel), 64'(rs), 64'(es));
      chk($sformatf("rnd%0d_sel%0d_ovf", n, rsel), 64'(rovf), 64'(eovf));
      chk($sformatf("rnd%0d_sel%0d_ill", n, rsel), 64'(rill), 64'(eill));
      chk($sformatf("rnd%0d_sel%0d_lat", n, rsel), 64'(rlat), (rsel == 5'd7) ? 64'd33 : 64'd1);
    end

    // Back-pressure: ADD 2+3 held for 10 cycles while new requests are offered.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.a = 32'd2; bus.b = 32'd3; bus.sel = 5'd1;
    @(posedge clk); #1;
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_s", 64'(bus.s), 64'd5);
    bus.a = 32'd9; bus.b = 32'd9; bus.sel = 5'd8;
    held_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (!bus.out_valid || bus.s !== 32'd5 || bus.overflow !== 1'b0 || bus.in_ready) held_bad = 1'b1;
    end
    chk("bp_held_10", 64'(held_bad), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);

    // Asynchronous reset at MUL cycle 10 discards the operation.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 32'd7; bus.b = 32'd6; bus.sel = 5'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("mid_mul_busy", 64'(bus.in_ready), 64'd0);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_mul_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_mul_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_mul_rst_s", 64'(bus.s), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(32'd1, 32'd1, 5'd1, rs, rovf, rill, rlat);
    chk("post_rst_add_s", 64'(rs), 64'd2);
    chk("post_rst_add_lat", 64'(rlat), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
